// File: rtl/mux_sel_rr_arbiter.sv
// Round-robin arbiter driving the 2-bit select of a shared 4:1 datapath mux; the owner keeps the grant until it releases.
// Optional hold-time limit with forced release is built only when MUX_SEL_ARB_TIMEOUT_EN is defined.
module mux_sel_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {
    IDLE,
    OWN
  } state_t;

  state_t     state_reg;
  logic [3:0] gnt_reg;
  logic [1:0] sel_reg;
  logic [1:0] ptr_reg;
  logic       busy_reg;

  logic [1:0] base_idx;
  logic [3:0] req_rot;
  logic [1:0] win_ofs;
  logic [1:0] win_idx;
  logic [3:0] win_onehot;
  logic       any_req;
  logic       natural_release;
  logic       force_release;
  logic       release_now;

  generate
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("mux_sel_rr_arbiter: MAX_HOLD must be in 2..255");
    end
  endgenerate

  // While owning, the search starts just past the owner so it is considered last.
  assign base_idx = (state_reg == OWN) ? (sel_reg + 2'd1) : ptr_reg;
  assign any_req  = |req;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
      logic [1:0] idx;
      assign idx         = base_idx + 2'(gi);
      assign req_rot[gi] = req[idx];
    end
  endgenerate

  always_comb begin
    win_ofs = 2'd0;
    if (req_rot[0])      win_ofs = 2'd0;
    else if (req_rot[1]) win_ofs = 2'd1;
    else if (req_rot[2]) win_ofs = 2'd2;
    else if (req_rot[3]) win_ofs = 2'd3;
  end

  assign win_idx = base_idx + win_ofs;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
      assign win_onehot[gi] = (win_idx == 2'(gi));
    end
  endgenerate

  assign natural_release = done[sel_reg] | ~req[sel_reg];
  assign release_now     = (state_reg == OWN) & (natural_release | force_release);

`ifdef MUX_SEL_ARB_TIMEOUT_EN
  logic [7:0] hold_cnt_reg;
  logic       timeout_reg;

  assign force_release = (state_reg == OWN) & ~natural_release &
                         (hold_cnt_reg == 8'(MAX_HOLD - 1));

  // Counts completed OWN cycles of the current grant; any grant or re-grant restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_reg <= 8'd0;
      timeout_reg  <= 1'b0;
    end else begin
      timeout_reg <= force_release;
      if (state_reg == OWN && !release_now) begin
        hold_cnt_reg <= hold_cnt_reg + 8'd1;
      end else begin
        hold_cnt_reg <= 8'd0;
      end
    end
  end

  assign timeout = timeout_reg;
`else
  assign force_release = 1'b0;
  assign timeout       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      gnt_reg   <= 4'd0;
      sel_reg   <= 2'd0;
      ptr_reg   <= 2'd0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            state_reg <= OWN;
            gnt_reg   <= win_onehot;
            sel_reg   <= win_idx;
            busy_reg  <= 1'b1;
          end else begin
            gnt_reg  <= 4'd0;
            busy_reg <= 1'b0;
          end
        end
        OWN: begin
          if (release_now) begin
            ptr_reg <= sel_reg + 2'd1;
            // Direct handover (or re-grant of the same owner) keeps gnt asserted with no idle bubble.
            if (any_req) begin
              gnt_reg  <= win_onehot;
              sel_reg  <= win_idx;
              busy_reg <= 1'b1;
            end else begin
              state_reg <= IDLE;
              gnt_reg   <= 4'd0;
              busy_reg  <= 1'b0;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          gnt_reg   <= 4'd0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt  = gnt_reg;
  assign sel  = sel_reg;
  assign busy = busy_reg;

endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// Bench for mux_sel_rr_arbiter: directed scenarios plus random traffic against an integer-level round-robin model.
module tb_mux_sel_rr_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: owner index (-1 = nobody), pointer, last select, cycles held, timeout flag.
  int m_owner;
  int m_ptr;
  int m_sel;
  int m_held;
  int m_to;
  int n_timeouts = 0;

  mux_sel_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int first_from(input int start, input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (start + k) % 4;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_sel   = 0;
    m_held  = 0;
    m_to    = 0;
  endtask

  task automatic model_edge(input logic [3:0] r, input logic [3:0] d);
    int  w;
    bit  nat;
    bit  forced;
    bit  to_en;
`ifdef MUX_SEL_ARB_TIMEOUT_EN
    to_en = 1'b1;
`else
    to_en = 1'b0;
`endif
    m_to = 0;
    if (m_owner < 0) begin
      w = first_from(m_ptr, r);
      if (w >= 0) begin
        m_owner = w;
        m_sel   = w;
        m_held  = 0;
      end
    end else begin
      nat    = d[m_owner] || !r[m_owner];
      forced = to_en && !nat && (m_held == MAX_HOLD - 1);
      if (nat || forced) begin
        m_ptr  = (m_owner + 1) % 4;
        m_to   = forced ? 1 : 0;
        m_held = 0;
        w = first_from(m_ptr, r);
        if (w >= 0) begin
          m_owner = w;
          m_sel   = w;
        end else begin
          m_owner = -1;
        end
      end else begin
        m_held++;
      end
    end
  endtask

  // One transaction: apply req/done for one clock, then compare all outputs to the model.
  task automatic step(input logic [3:0] r, input logic [3:0] d);
    logic [3:0] exp_gnt;
    req  = r;
    done = d;
    @(posedge clk);
    model_edge(r, d);
    #1;
    exp_gnt = (m_owner < 0) ? 4'd0 : 4'(1 << m_owner);
    if (m_to != 0) n_timeouts++;
    $display("[TB] t=%0t req=%b done=%b gnt=%b sel=%0d busy=%0b timeout=%0b", $time, r, d, gnt, sel, busy, timeout);
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("sel", 32'(sel), 32'(m_sel));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    check("timeout", 32'(timeout), 32'(m_to));
  endtask

  initial begin
    logic [3:0] r_rand;
    logic [3:0] d_rand;

    model_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    done  = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check("reset_gnt", 32'(gnt), 32'h0);
    check("reset_sel", 32'(sel), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_timeout", 32'(timeout), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1111, 4'b0000);
    check("first_grant", 32'(gnt), 32'h1);
    step(4'b0000, 4'b0001);
    check("release_idle", 32'(gnt), 32'h0);

    // Single requester, then release via done with req dropped; ptr should land on 3.
    step(4'b0100, 4'b0000);
    check("single_gnt", 32'(gnt), 32'h4);
    check("single_sel", 32'(sel), 32'h2);
    step(4'b0000, 4'b0100);
    check("single_rel_busy", 32'(busy), 32'h0);
    step(4'b1111, 4'b0000);
    check("ptr_after_2", 32'(gnt), 32'h8);

    // Rotation with owner pulsing done each grant: 3,0,1,2,3,0 with no bubble.
    step(4'b1111, 4'b1000);
    check("rot0", 32'(gnt), 32'h1);
    step(4'b1111, 4'b0001);
    check("rot1", 32'(gnt), 32'h2);
    step(4'b1111, 4'b0010);
    check("rot2", 32'(gnt), 32'h4);
    step(4'b1111, 4'b0100);
    check("rot3", 32'(gnt), 32'h8);
    step(4'b1111, 4'b1000);
    check("rot_wrap", 32'(gnt), 32'h1);

    // Owner 1, foreign done bits ignored, then req[1] drop hands to index 2.
    step(4'b0010, 4'b0001);
    check("own1", 32'(gnt), 32'h2);
    step(4'b1111, 4'b1101);
    check("ignored_done", 32'(gnt), 32'h2);
    step(4'b1101, 4'b0000);
    check("req_drop", 32'(gnt), 32'h4);

    // Owner 3, then asynchronous reset in mid-cycle.
    step(4'b1000, 4'b0100);
    check("own3", 32'(gnt), 32'h8);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_gnt", 32'(gnt), 32'h0);
    check("async_sel", 32'(sel), 32'h0);
    check("async_busy", 32'(busy), 32'h0);
    req  = 4'b0000;
    done = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Owner 0 never releases while 1 also requests.
    step(4'b0011, 4'b0000);
    check("hold_start", 32'(gnt), 32'h1);
    for (int i = 0; i < 100; i++) begin
      step(4'b0011, 4'b0000);
`ifndef MUX_SEL_ARB_TIMEOUT_EN
      check("hold_forever", 32'(gnt), 32'h1);
`endif
    end
`ifdef MUX_SEL_ARB_TIMEOUT_EN
    check("timeouts_seen", 32'(n_timeouts > 0), 32'h1);
`endif
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);

    // Random traffic: sticky requests, sparse done strobes.
    r_rand = 4'b0000;
    for (int i = 0; i < 2000; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(7, 0) == 0) r_rand[b] = ~r_rand[b];
      end
      for (int b = 0; b < 4; b++) begin
        d_rand[b] = ($urandom_range(5, 0) == 0);
      end
      step(r_rand, d_rand);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
